axi4s_rq_read_gen: RTL and testbench

//  Source stage for the PCIe AXI4-Stream RQ interface (UltraScale-style descriptors).
//  - Turns read commands into single-beat Memory Read request descriptors and assigns each a PCIe tag.
//  - Sinks the matching RC completion stream and frees a tag when its final completion arrives.
//  - Reports completion status and completions that do not match an outstanding request.

---
 rtl/axi4s_rq_read_gen_if.sv | 53 +++++
 rtl/axi4s_rq_read_gen.sv | 145 ++++++++++++++
 tb/tb_axi4s_rq_read_gen.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4s_rq_read_gen_if.sv
`timescale 1ns/1ps
// Bundle of command, RQ request, RC completion and status signals for the
// PCIe memory-read request generator.
interface axi4s_rq_read_gen_if #(
  parameter int DATA_WIDTH = 256,
  parameter int RQ_USER_W  = 60,
  parameter int RC_USER_W  = 75
);
  logic [63:0]            cmd_addr;
  logic [10:0]            cmd_len;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [7:0]             cmd_tag;

  logic [DATA_WIDTH-1:0]  rq_tdata;
  logic [RQ_USER_W-1:0]   rq_tuser;
  logic [7:0]             rq_tkeep;
  logic                   rq_tlast;
  logic                   rq_tvalid;
  logic                   rq_tready;

  logic [DATA_WIDTH-1:0]  rc_tdata;
  logic [RC_USER_W-1:0]   rc_tuser;
  logic                   rc_tlast;
  logic                   rc_tvalid;
  logic                   rc_tready;

  logic                   done_vld;
  logic [7:0]             done_tag;
  logic [2:0]             done_sts;
  logic                   err_unexp;
  logic [8:0]             outstanding;

  modport master (
    input  cmd_addr, cmd_len, cmd_valid,
    output cmd_ready, cmd_tag,
    output rq_tdata, rq_tuser, rq_tkeep, rq_tlast, rq_tvalid,
    input  rq_tready,
    input  rc_tdata, rc_tuser, rc_tlast, rc_tvalid,
    output rc_tready,
    output done_vld, done_tag, done_sts, err_unexp, outstanding
  );

  modport slave (
    output cmd_addr, cmd_len, cmd_valid,
    input  cmd_ready, cmd_tag,
    input  rq_tdata, rq_tuser, rq_tkeep, rq_tlast, rq_tvalid,
    output rq_tready,
    output rc_tdata, rc_tuser, rc_tlast, rc_tvalid,
    input  rc_tready,
    input  done_vld, done_tag, done_sts, err_unexp, outstanding
  );
endinterface

// File: rtl/axi4s_rq_read_gen.sv
`timescale 1ns/1ps
// Issues single-beat PCIe Memory Read descriptors on RQ with tags from a pool,
// and retires tags when the RC stream reports their final completion.
module axi4s_rq_read_gen #(
  parameter int          TAGS      = 32,
  parameter int          MAX_RD_DW = 128,
  parameter logic [15:0] REQ_ID    = 16'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi4s_rq_read_gen_if.master  bus
);

  typedef enum logic {RC_FIRST, RC_BODY} rc_state_t;

  rc_state_t        rc_state, rc_state_next;
  logic [TAGS-1:0]  busy, busy_next, alloc_mask, free_mask;
  logic [8:0]       busy_count, outstanding;
  logic [7:0]       free_idx;
  logic             any_free;
  logic             run;
  logic             cmd_fire;
  logic             rc_beat, rc_first_beat;
  logic [7:0]       rc_tag;
  logic             tag_busy, tag_done;
  logic             rq_tvalid;
  logic [127:0]     rq_desc;
  logic [7:0]       rq_be;
  logic             done_vld, err_unexp;
  logic [7:0]       done_tag;
  logic [2:0]       done_sts;
  logic             unused_bits;

  // Lowest-index free tag: scanning downward lets the last hit win.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = 8'(i);
        any_free = 1'b1;
      end
    end
  end

  // run doubles as rc_tready; it also keeps the command side quiet in reset.
  assign bus.cmd_ready = run && any_free && (!rq_tvalid || bus.rq_tready);
  assign bus.cmd_tag   = run ? free_idx : '0;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

  assign rc_beat       = bus.rc_tvalid && run;
  assign rc_first_beat = rc_beat && (rc_state == RC_FIRST);
  assign rc_tag        = bus.rc_tdata[71:64];

  // Tags at or above TAGS never match, so they fall out as unexpected.
  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < TAGS; i++) begin
      if (rc_tag == 8'(i)) tag_busy = busy[i];
    end
  end

  assign tag_done = rc_first_beat && tag_busy && bus.rc_tdata[30];

  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    busy_count = '0;
    for (int i = 0; i < TAGS; i++) begin
      if (cmd_fire && (free_idx == 8'(i))) alloc_mask[i] = 1'b1;
      if (tag_done && (rc_tag == 8'(i)))   free_mask[i]  = 1'b1;
    end
    busy_next = (busy | alloc_mask) & ~free_mask;
    for (int i = 0; i < TAGS; i++) busy_count = busy_count + 9'(busy_next[i]);
  end

  always_comb begin
    rc_state_next = rc_state;
    if (rc_beat) rc_state_next = bus.rc_tlast ? RC_FIRST : RC_BODY;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rc_state <= RC_FIRST;
    else        rc_state <= rc_state_next;
  end

  // NOTE: the tag bitmap is a flop vector, not a RAM, so resetting it is cheap and required.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      busy        <= '0;
      outstanding <= '0;
      rq_tvalid   <= 1'b0;
      rq_desc     <= '0;
      rq_be       <= '0;
      done_vld    <= 1'b0;
      done_tag    <= '0;
      done_sts    <= '0;
      err_unexp   <= 1'b0;
    end else begin
      run         <= 1'b1;
      busy        <= busy_next;
      outstanding <= busy_count;
      if (cmd_fire) begin
        rq_tvalid <= 1'b1;
        rq_desc   <= {24'h0, free_idx, REQ_ID, 1'b0, 4'b0000,
                      bus.cmd_len, bus.cmd_addr[63:2], 2'b00};
        rq_be     <= {(bus.cmd_len == 11'd1) ? 4'h0 : 4'hF, 4'hF};
      end else if (bus.rq_tready) begin
        rq_tvalid <= 1'b0;
      end
      done_vld  <= tag_done;
      if (tag_done) begin
        done_tag <= rc_tag;
        done_sts <= bus.rc_tdata[45:43];
      end
      err_unexp <= rc_first_beat && !tag_busy;
    end
  end

  always_comb begin
    bus.rq_tdata        = '0;
    bus.rq_tdata[127:0] = rq_desc;
    bus.rq_tuser        = '0;
    bus.rq_tuser[7:0]   = rq_be;
  end

  assign bus.rq_tkeep    = 8'h0F;
  assign bus.rq_tlast    = 1'b1;
  assign bus.rq_tvalid   = rq_tvalid;
  assign bus.rc_tready   = run;
  assign bus.done_vld    = done_vld;
  assign bus.done_tag    = done_tag;
  assign bus.done_sts    = done_sts;
  assign bus.err_unexp   = err_unexp;
  assign bus.outstanding = outstanding;

  // Length legality is the command source's responsibility; these fields are not interpreted.
  assign unused_bits = ^{bus.rc_tuser, bus.rc_tdata[255:72], bus.rc_tdata[63:46],
                         bus.rc_tdata[42:31], bus.rc_tdata[29:0], bus.cmd_addr[1:0],
                         MAX_RD_DW[0]};

endmodule

// File: tb/tb_axi4s_rq_read_gen.sv
`timescale 1ns/1ps
// Directed bench for axi4s_rq_read_gen: scoreboards for RQ beats and DONE pulses,
// plus timing checks around tag allocation, stalls, partial completions and reset.
module tb_axi4s_rq_read_gen;
  localparam int          TAGS      = 32;
  localparam int          MAX_RD_DW = 128;
  localparam logic [15:0] REQ_ID    = 16'hA5C3;

  typedef struct packed {
    logic [255:0] data;
    logic [59:0]  user;
  } rq_beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4s_rq_read_gen_if bif();

  axi4s_rq_read_gen #(.TAGS(TAGS), .MAX_RD_DW(MAX_RD_DW), .REQ_ID(REQ_ID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  rq_beat_t    rq_q[$];
  logic [10:0] done_q[$];
  int n_checks = 0, n_errors = 0;
  int n_done_seen = 0, n_done_exp = 0, n_err_seen = 0, n_err_exp = 0;
  rq_beat_t    mon_beat;
  logic [10:0] mon_done;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rq_beat_t mk_beat(input logic [63:0] addr, input logic [10:0] len,
                                       input logic [7:0] tag);
    rq_beat_t r;
    r.data          = '0;
    r.data[63:2]    = addr[63:2];
    r.data[74:64]   = len;
    r.data[95:80]   = REQ_ID;
    r.data[103:96]  = tag;
    r.user          = '0;
    r.user[3:0]     = 4'hF;
    r.user[7:4]     = (len == 11'd1) ? 4'h0 : 4'hF;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [63:0] addr, input logic [10:0] len, input logic [7:0] exp_tag);
    bit seen = 1'b0;
    assert (len >= 11'd1 && len <= 11'(MAX_RD_DW))
      else $fatal(1, "FAIL illegal_cmd_len: observed %0d expected 1..%0d", len, MAX_RD_DW);
    bif.cmd_addr  = addr;
    bif.cmd_len   = len;
    bif.cmd_valid = 1'b1;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = bif.cmd_ready;
    end
    if (!seen) begin
      check("cmd_ready_timeout", bif.cmd_ready, 1'b1);
    end else begin
      check("cmd_tag", bif.cmd_tag, exp_tag);
      rq_q.push_back(mk_beat(addr, len, exp_tag));
      tick();
    end
    bif.cmd_valid = 1'b0;
  endtask

  task automatic rc_send(input logic [7:0] tag, input logic cpl, input logic [2:0] sts,
                         input int beats, input bit exp_done, input bit exp_err);
    logic [255:0] d;
    logic [95:0]  u;
    if (exp_done) begin
      done_q.push_back({tag, sts});
      n_done_exp++;
    end
    if (exp_err) n_err_exp++;
    for (int b = 0; b < beats; b++) begin
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      u = {$urandom, $urandom, $urandom};
      // Continuation beats look like completing descriptors and must be ignored.
      d[71:64] = tag;
      d[30]    = (b == 0) ? cpl : 1'b1;
      if (b == 0) d[45:43] = sts;
      bif.rc_tdata  = d;
      bif.rc_tuser  = u[74:0];
      bif.rc_tlast  = (b == beats - 1);
      bif.rc_tvalid = 1'b1;
      tick();
      if (b == 0) begin
        check("rc_done_vld", bif.done_vld, exp_done);
        check("rc_err_unexp", bif.err_unexp, exp_err);
      end
    end
    bif.rc_tvalid = 1'b0;
    bif.rc_tlast  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bif.rq_tvalid && bif.rq_tready) begin
      if (rq_q.size() == 0) begin
        check("rq_spurious_beat", bif.rq_tvalid, 1'b0);
      end else begin
        mon_beat = rq_q.pop_front();
        check("rq_tdata", bif.rq_tdata, mon_beat.data);
        check("rq_tuser", bif.rq_tuser, mon_beat.user);
        check("rq_tkeep", bif.rq_tkeep, 8'h0F);
        check("rq_tlast", bif.rq_tlast, 1'b1);
      end
    end
    if (rst_n && bif.done_vld) begin
      n_done_seen++;
      if (done_q.size() > 0) begin
        mon_done = done_q.pop_front();
        check("done_tag_sts", {bif.done_tag, bif.done_sts}, mon_done);
      end
    end
    if (rst_n && bif.err_unexp) n_err_seen++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rq_beat_t exp_stall;
    time t0, t1;

    bif.cmd_addr  = '0;
    bif.cmd_len   = '0;
    bif.cmd_valid = 1'b0;
    bif.rq_tready = 1'b1;
    bif.rc_tdata  = '0;
    bif.rc_tuser  = '0;
    bif.rc_tlast  = 1'b0;
    bif.rc_tvalid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rq_tvalid", bif.rq_tvalid, 1'b0);
    check("rst_rc_tready", bif.rc_tready, 1'b0);
    check("rst_done_vld", bif.done_vld, 1'b0);
    check("rst_err_unexp", bif.err_unexp, 1'b0);
    check("rst_outstanding", bif.outstanding, 9'd0);
    check("rst_cmd_ready", bif.cmd_ready, 1'b0);
    check("rst_cmd_tag", bif.cmd_tag, 8'd0);
    check("rst_rq_tdata", bif.rq_tdata, 256'd0);
    check("rst_rq_tuser", bif.rq_tuser, 60'd0);
    check("rst_done_tag_sts", {bif.done_tag, bif.done_sts}, 11'd0);
    rst_n = 1'b1;
    #1;
    check("release_rc_tready_low", bif.rc_tready, 1'b0);
    tick();
    check("release_rc_tready_high", bif.rc_tready, 1'b1);

    // 1: single read and its completion
    send_cmd(64'h1000, 11'd4, 8'd0);
    @(negedge clk);
    check("t1_outstanding_busy", bif.outstanding, 9'd1);
    rc_send(8'd0, 1'b1, 3'd0, 1, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_outstanding_free", bif.outstanding, 9'd0);

    // 2: exhaust the pool back-to-back, including len 1 and len MAX
    tick();
    t0 = $time;
    for (int i = 0; i < TAGS; i++) begin
      send_cmd(64'h0000_0002_0000_0000 + 64'(i) * 64,
               (i == 0) ? 11'd1 : (i == 1) ? 11'(MAX_RD_DW) : 11'(i), 8'(i));
    end
    t1 = $time;
    check("t2_burst_cycles", 256'((t1 - t0) / 10), 256'(TAGS));

    // 3: hold a 33rd command, then free tag 5
    bif.cmd_addr  = 64'h0000_0000_DEAD_0000;
    bif.cmd_len   = 11'd8;
    bif.cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t2_full_cmd_ready", bif.cmd_ready, 1'b0);
    end
    check("t2_full_outstanding", bif.outstanding, 9'd32);
    tick();
    bif.rc_tdata        = '0;
    bif.rc_tdata[71:64] = 8'd5;
    bif.rc_tdata[30]    = 1'b1;
    bif.rc_tdata[45:43] = 3'b100;
    bif.rc_tlast        = 1'b1;
    bif.rc_tvalid       = 1'b1;
    done_q.push_back({8'd5, 3'b100});
    n_done_exp++;
    @(negedge clk);
    check("t3_free_cycle_cmd_ready", bif.cmd_ready, 1'b0);
    tick();
    bif.rc_tvalid = 1'b0;
    bif.rc_tlast  = 1'b0;
    @(negedge clk);
    check("t3_done_vld", bif.done_vld, 1'b1);
    check("t3_no_issue_with_done", bif.rq_tvalid, 1'b0);
    check("t3_cmd_ready", bif.cmd_ready, 1'b1);
    check("t3_cmd_tag", bif.cmd_tag, 8'd5);
    rq_q.push_back(mk_beat(64'h0000_0000_DEAD_0000, 11'd8, 8'd5));
    tick();
    bif.cmd_valid = 1'b0;
    @(negedge clk);
    check("t3_issue_tvalid", bif.rq_tvalid, 1'b1);
    check("t3_issue_tag", bif.rq_tdata[103:96], 8'd5);
    check("t3_outstanding", bif.outstanding, 9'd32);

    // 4: RQ back-pressure
    rc_send(8'd10, 1'b1, 3'd0, 1, 1'b1, 1'b0);
    rc_send(8'd11, 1'b1, 3'b001, 2, 1'b1, 1'b0);
    @(negedge clk);
    check("t4_outstanding_before", bif.outstanding, 9'd30);
    tick();
    bif.rq_tready = 1'b0;
    send_cmd(64'h0000_0001_2345_6780, 11'd16, 8'd10);
    exp_stall = mk_beat(64'h0000_0001_2345_6780, 11'd16, 8'd10);
    bif.cmd_addr  = 64'h0000_0000_0000_9000;
    bif.cmd_len   = 11'd2;
    bif.cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4_stall_tvalid", bif.rq_tvalid, 1'b1);
      check("t4_stall_tdata", bif.rq_tdata, exp_stall.data);
      check("t4_stall_cmd_ready", bif.cmd_ready, 1'b0);
    end
    check("t4_stall_outstanding", bif.outstanding, 9'd31);
    tick();
    bif.cmd_valid = 1'b0;
    bif.rq_tready = 1'b1;
    tick();
    send_cmd(64'h0000_0000_0000_9000, 11'd2, 8'd11);
    @(negedge clk);
    check("t4_outstanding_after", bif.outstanding, 9'd32);

    // 5: partial then final completion, and unexpected tags
    rc_send(8'd3, 1'b0, 3'd0, 3, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_partial_outstanding", bif.outstanding, 9'd32);
    rc_send(8'd3, 1'b1, 3'b010, 3, 1'b1, 1'b0);
    @(negedge clk);
    check("t5_final_outstanding", bif.outstanding, 9'd31);
    rc_send(8'd7, 1'b1, 3'd0, 1, 1'b1, 1'b0);
    rc_send(8'd7, 1'b1, 3'd0, 1, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_unexp_outstanding", bif.outstanding, 9'd30);
    rc_send(8'(TAGS), 1'b1, 3'd0, 1, 1'b0, 1'b1);
    rc_send(8'd255, 1'b1, 3'd0, 2, 1'b0, 1'b1);
    @(negedge clk);
    check("t5_range_outstanding", bif.outstanding, 9'd30);

    // 6: reset with 4 tags busy and a stalled RQ beat
    tick();
    rst_n = 1'b0;
    rq_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_cmd(64'h100, 11'd1, 8'd0);
    send_cmd(64'h200, 11'd2, 8'd1);
    send_cmd(64'h300, 11'd3, 8'd2);
    tick();
    bif.rq_tready = 1'b0;
    send_cmd(64'h400, 11'd4, 8'd3);
    @(negedge clk);
    check("t6_outstanding_busy", bif.outstanding, 9'd4);
    check("t6_rq_stalled", bif.rq_tvalid, 1'b1);
    bif.rc_tdata        = '0;
    bif.rc_tdata[71:64] = 8'd0;
    bif.rc_tlast        = 1'b0;
    bif.rc_tvalid       = 1'b1;
    tick();
    bif.rc_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    rq_q.delete();
    #1;
    check("t6_rst_rq_tvalid", bif.rq_tvalid, 1'b0);
    check("t6_rst_outstanding", bif.outstanding, 9'd0);
    check("t6_rst_cmd_ready", bif.cmd_ready, 1'b0);
    check("t6_rst_rc_tready", bif.rc_tready, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    bif.rq_tready = 1'b1;
    send_cmd(64'h0000_0000_0000_5000, 11'(MAX_RD_DW), 8'd0);
    rc_send(8'd0, 1'b1, 3'b111, 1, 1'b1, 1'b0);
    @(negedge clk);
    check("t6_final_outstanding", bif.outstanding, 9'd0);

    repeat (3) @(negedge clk);
    check("end_rq_queue_empty", 256'(rq_q.size()), 256'd0);
    check("end_done_count", 256'(n_done_seen), 256'(n_done_exp));
    check("end_err_count", 256'(n_err_seen), 256'(n_err_exp));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
